// File: rtl/sr_imem_dmem_arbiter.sv
// Round-robin arbiter that shares one in-order, fixed-latency memory port between
// instruction fetch (IF) and data load (LD), routing each response back by tag.
module sr_imem_dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic                         if_req_vld,
    input  logic [AW-1:0]                if_req_addr,
    output logic                         if_req_rdy,
    output logic                         if_rsp_vld,
    output logic [DW-1:0]                if_rsp_data,

    input  logic                         ld_req_vld,
    input  logic [AW-1:0]                ld_req_addr,
    output logic                         ld_req_rdy,
    output logic                         ld_rsp_vld,
    output logic [DW-1:0]                ld_rsp_data,

    output logic                         mem_addr_vld,
    output logic [AW-1:0]                mem_addr,
    input  logic                         mem_data_vld,
    input  logic [DW-1:0]                mem_data,

    output logic [$clog2(MAX_OUTST):0]   outstanding,
    output logic                         err_unexpected
);

    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;

    localparam logic ID_IF = 1'b0;
    localparam logic ID_LD = 1'b1;

    // Handshake: a requester holds valid and address stable until its rdy is
    // high in a cycle; that cycle is the grant, and the address goes to memory
    // in the same cycle. Responses carry no backpressure.

    logic [MAX_OUTST-1:0] r_tag;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_outstanding;
    logic                 r_last_grant;
    logic                 r_err;

    logic                 w_empty;
    logic                 w_can_acc;
    logic                 w_grant_if;
    logic                 w_grant_ld;
    logic                 w_push;
    logic                 w_push_id;
    logic                 w_pop;
    logic                 w_head;

    assign w_empty = (r_outstanding == '0);

    // A response popping this cycle frees a slot for a grant in the same cycle.
    assign w_can_acc = reset_n & ((r_outstanding < CW'(MAX_OUTST)) | mem_data_vld);

    always_comb begin
        w_grant_if = 1'b0;
        w_grant_ld = 1'b0;
        if (w_can_acc) begin
            if (if_req_vld && ld_req_vld) begin
                if (r_last_grant == ID_LD) begin
                    w_grant_if = 1'b1;
                end else begin
                    w_grant_ld = 1'b1;
                end
            end else if (if_req_vld) begin
                w_grant_if = 1'b1;
            end else if (ld_req_vld) begin
                w_grant_ld = 1'b1;
            end
        end
    end

    assign w_push    = w_grant_if | w_grant_ld;
    assign w_push_id = w_grant_ld ? ID_LD : ID_IF;
    assign w_pop     = reset_n & mem_data_vld & ~w_empty;
    assign w_head    = r_tag[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag    <= '0;
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_tag[r_wr_ptr] <= w_push_id;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Reset to LD so IF wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= ID_LD;
        end else if (w_push) begin
            r_last_grant <= w_push_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (mem_data_vld && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign if_req_rdy     = w_grant_if;
    assign ld_req_rdy     = w_grant_ld;
    assign mem_addr_vld   = w_push;
    assign mem_addr       = w_grant_if ? if_req_addr :
                            w_grant_ld ? ld_req_addr : '0;

    assign if_rsp_vld     = w_pop & (w_head == ID_IF);
    assign ld_rsp_vld     = w_pop & (w_head == ID_LD);
    assign if_rsp_data    = mem_data;
    assign ld_rsp_data    = mem_data;

    assign outstanding    = r_outstanding;
    assign err_unexpected = r_err;

endmodule
